// File: rtl/arm_shift_pipe.sv
// ARM barrel shifter (LSL/LSR/ASR/ROR/RRX) with valid/ready handshake and registered outputs.
// Define SFT_PIPE2_EN to split into two stages (decode + coarse rotate, then fine rotate + mask + carry).
module arm_shift_pipe #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] INA,
  input  logic [1:0]       SHTYPE,
  input  logic [7:0]       AMOUNT,
  input  logic             IMM,
  input  logic             CIN,
  input  logic [TAGW-1:0]  TAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT,
  output logic             COUT,
  output logic [TAGW-1:0]  TAG_OUT
);

  localparam int         L     = $clog2(WIDTH);
  localparam int         FL    = (L + 1) / 2;
  localparam logic [L:0] N_AMT = (L+1)'(WIDTH);
  localparam logic [7:0] N_8   = 8'(WIDTH);

  typedef enum logic [2:0] {
    OP_PASS, OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX
  } op_e;

  // amt is the effective amount clamped to N (over flags n > N); rot is the right-rotate distance.
  typedef struct packed {
    op_e              op;
    logic             over;
    logic             sign;
    logic             cin;
    logic [L:0]       amt;
    logic [L-1:0]     rot;
    logic [WIDTH-1:0] data;
    logic [TAGW-1:0]  tag;
  } dec_t;

  function automatic logic [WIDTH-1:0] rotr_lvls(input logic [WIDTH-1:0] d,
                                                 input logic [L-1:0] r,
                                                 input int lo, input int hi);
    logic [WIDTH-1:0] v;
    v = d;
    for (int k = 0; k < L; k++) begin
      if (k >= lo && k < hi && r[k]) v = (v >> (1 << k)) | (v << (WIDTH - (1 << k)));
    end
    return v;
  endfunction

  dec_t             dec_c, crs_c, fin_s;
  logic [7:0]       n_c;
  logic [WIDTH-1:0] rot_f, keep_l, keep_r, res_c;
  logic             cout_c;
  logic             s2_can, take, load_out;
  logic             out_valid_q, out_valid_d, cout_q, cout_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [TAGW-1:0]  tag_q, tag_d;

  always_comb begin
    n_c            = IMM ? 8'(AMOUNT[L-1:0]) : AMOUNT;
    dec_c          = '0;
    dec_c.data     = INA;
    dec_c.cin      = CIN;
    dec_c.tag      = TAG;
    dec_c.sign     = INA[WIDTH-1];
    dec_c.over     = n_c > N_8;
    dec_c.amt      = dec_c.over ? N_AMT : n_c[L:0];
    dec_c.rot      = n_c[L-1:0];
    case (SHTYPE)
      2'b00:   dec_c.op = OP_LSL;
      2'b01:   dec_c.op = OP_LSR;
      2'b10:   dec_c.op = OP_ASR;
      default: dec_c.op = OP_ROR;
    endcase
    // Zero amount: register form and LSL #0 pass through; LSR/ASR #0 mean #N; ROR #0 is RRX.
    if (n_c == 8'd0) begin
      if (!IMM || SHTYPE == 2'b00) dec_c.op = OP_PASS;
      else if (SHTYPE == 2'b11) begin
        dec_c.op  = OP_RRX;
        dec_c.rot = L'(1);
      end else dec_c.amt = N_AMT;
    end
    if (dec_c.op == OP_LSL) dec_c.rot = -n_c[L-1:0];
  end

  always_comb begin
    crs_c      = dec_c;
    crs_c.data = rotr_lvls(dec_c.data, dec_c.rot, FL, L);
  end

  // Handshake: a transfer happens on a port only at a rising edge where its valid and ready are
  // both high; ready never looks at the same port's valid, and the output holds until taken.
  assign s2_can = !out_valid_q || OUT_READY;

`ifdef SFT_PIPE2_EN
  logic s1_valid_q, s1_valid_d, adv;
  dec_t s1_q, s1_d;

  assign adv      = s1_valid_q && s2_can;
  assign IN_READY = !RST && (!s1_valid_q || s2_can);
  assign take     = IN_VALID && IN_READY;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (take) begin
      s1_valid_d = 1'b1;
      s1_d       = crs_c;
    end else if (adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
    end
  end

  assign fin_s    = s1_q;
  assign load_out = adv;
`else
  assign IN_READY = !RST && s2_can;
  assign take     = IN_VALID && IN_READY;
  assign fin_s    = crs_c;
  assign load_out = take;
`endif

  always_comb begin
    rot_f = rotr_lvls(fin_s.data, fin_s.rot, 0, FL);
    for (int i = 0; i < WIDTH; i++) begin
      keep_l[i] = i >= int'(fin_s.amt);
      keep_r[i] = (i + int'(fin_s.amt)) < WIDTH;
    end
    res_c  = rot_f;
    cout_c = rot_f[WIDTH-1];
    case (fin_s.op)
      OP_PASS: begin
        res_c  = fin_s.data;
        cout_c = fin_s.cin;
      end
      OP_LSL: begin
        res_c  = rot_f & keep_l;
        cout_c = !fin_s.over && rot_f[0];
      end
      OP_LSR: begin
        res_c  = rot_f & keep_r;
        cout_c = !fin_s.over && rot_f[WIDTH-1];
      end
      OP_ASR: begin
        res_c  = (rot_f & keep_r) | ({WIDTH{fin_s.sign}} & ~keep_r);
        cout_c = fin_s.over ? fin_s.sign : rot_f[WIDTH-1];
      end
      OP_RRX:  res_c = {fin_s.cin, rot_f[WIDTH-2:0]};
      default: ;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    cout_d      = cout_q;
    tag_d       = tag_q;
    if (load_out) begin
      out_valid_d = 1'b1;
      out_d       = res_c;
      cout_d      = cout_c;
      tag_d       = fin_s.tag;
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      cout_q      <= 1'b0;
      tag_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      cout_q      <= cout_d;
      tag_q       <= tag_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT       = out_q;
  assign COUT      = cout_q;
  assign TAG_OUT   = tag_q;

endmodule

// File: tb/tb_arm_shift_pipe.sv
// Self-checking bench for arm_shift_pipe (WIDTH=32): directed table, stall/reset sequences, random traffic.
module tb_arm_shift_pipe;
  localparam int W  = 32;
  localparam int TW = 4;
  localparam int EW = W + 1 + TW;
`ifdef SFT_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          CLK, RST, IN_VALID, IN_READY, IMM, CIN, OUT_VALID, OUT_READY, COUT;
  logic [W-1:0]  INA, OUT;
  logic [1:0]    SHTYPE;
  logic [7:0]    AMOUNT;
  logic [TW-1:0] TAG, TAG_OUT;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int total = 0;
  int bad = 0;
  int out_seen = 0;

  arm_shift_pipe #(.WIDTH(W), .TAGW(TW)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .INA(INA),
    .SHTYPE(SHTYPE), .AMOUNT(AMOUNT), .IMM(IMM), .CIN(CIN), .TAG(TAG),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT(OUT), .COUT(COUT), .TAG_OUT(TAG_OUT)
  );

  // clock / watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, expv);
    end
  endtask

  // reference model: {out, cout} from the architectural shift rules
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [1:0] t,
                                       input logic [7:0] amt, input logic imm, input logic c);
    int n;
    logic [63:0] x;
    logic signed [63:0] sx;
    logic [W-1:0] r;
    n = imm ? int'(amt) % W : int'(amt);
    if (imm && n == 0) begin
      if (t == 2'b00) return {a, c};
      if (t == 2'b11) return {{c, a[W-1:1]}, a[0]};
      n = W;
    end
    if (n == 0) return {a, c};
    case (t)
      2'b00: begin
        if (n > W) return '0;
        x = {32'b0, a} << n;
        return {x[31:0], x[32]};
      end
      2'b01: begin
        if (n > W) return '0;
        x = {a, 32'b0} >> n;
        return {x[63:32], x[31]};
      end
      2'b10: begin
        if (n >= W) return {{W{a[W-1]}}, a[W-1]};
        sx = $signed({a, 32'b0}) >>> n;
        return {sx[63:32], sx[31]};
      end
      default: begin
        n = n % W;
        if (n == 0) return {a, a[W-1]};
        r = (a >> n) | (a << (W - n));
        return {r, r[W-1]};
      end
    endcase
  endfunction

  // driver: enters and leaves 1 ns after a rising edge
  task automatic send(input logic [W-1:0] a, input logic [1:0] t, input logic [7:0] amt,
                      input logic imm, input logic c, input logic [TW-1:0] tg, input logic [W:0] e);
    bit ok = 0;
    INA = a; SHTYPE = t; AMOUNT = amt; IMM = imm; CIN = c; TAG = tg; IN_VALID = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (IN_READY) begin
        ok = 1;
        break;
      end
      @(posedge CLK);
      #1;
    end
    if (ok) begin
      @(posedge CLK);
      exp_q.push_back({e, tg});
      #1;
    end else begin
      total++;
      bad++;
      $display("FAIL send_timeout tag=%0d in_ready=%b exp_ready=1", tg, IN_READY);
    end
    IN_VALID = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge CLK);
    #1;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard: compare every output transfer against the queue head
  always @(negedge CLK) begin
    if (!RST && OUT_VALID && OUT_READY) begin
      out_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out got tag=%0d out=%h exp=none", TAG_OUT, OUT);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result{out,cout,tag}", 64'({OUT, COUT, TAG_OUT}), 64'(mon_e));
      end
    end
  end

  typedef struct {
    logic [W-1:0] a;
    logic [1:0]   t;
    logic [7:0]   amt;
    logic         imm;
    logic         c;
    logic [W-1:0] eo;
    logic         ec;
  } vec_t;

  vec_t tbl[16];
  int lat, seen0;
  bit dropped, rnd_done;
  logic [W-1:0] ra;
  logic [1:0] rt;
  logic [7:0] ramt;
  logic ri, rc;

  initial begin
    tbl[0]  = '{32'h00000001, 2'b00, 8'd32,   1'b0, 1'b0, 32'h00000000, 1'b1};
    tbl[1]  = '{32'h00000001, 2'b00, 8'd33,   1'b0, 1'b1, 32'h00000000, 1'b0};
    tbl[2]  = '{32'h80000000, 2'b01, 8'd0,    1'b1, 1'b0, 32'h00000000, 1'b1};
    tbl[3]  = '{32'h80000000, 2'b10, 8'd40,   1'b0, 1'b0, 32'hFFFFFFFF, 1'b1};
    tbl[4]  = '{32'h00000003, 2'b11, 8'd0,    1'b1, 1'b1, 32'h80000001, 1'b1};
    tbl[5]  = '{32'h80000000, 2'b11, 8'd64,   1'b0, 1'b0, 32'h80000000, 1'b1};
    tbl[6]  = '{32'h12345678, 2'b00, 8'd0,    1'b0, 1'b1, 32'h12345678, 1'b1};
    tbl[7]  = '{32'h100000F1, 2'b00, 8'd4,    1'b1, 1'b0, 32'h00000F10, 1'b1};
    tbl[8]  = '{32'h12345680, 2'b01, 8'd8,    1'b0, 1'b0, 32'h00123456, 1'b1};
    tbl[9]  = '{32'h7FFFFFFF, 2'b10, 8'd0,    1'b1, 1'b1, 32'h00000000, 1'b0};
    tbl[10] = '{32'h00000012, 2'b11, 8'd4,    1'b0, 1'b1, 32'h20000001, 1'b0};
    tbl[11] = '{32'h7FFFFFFF, 2'b01, 8'd32,   1'b0, 1'b1, 32'h00000000, 1'b0};
    tbl[12] = '{32'h80000001, 2'b10, 8'd1,    1'b0, 1'b0, 32'hC0000000, 1'b1};
    tbl[13] = '{32'h0000000F, 2'b11, 8'd36,   1'b0, 1'b0, 32'hF0000000, 1'b1};
    tbl[14] = '{32'h80000001, 2'b00, 8'h21,   1'b1, 1'b0, 32'h00000002, 1'b1};
    tbl[15] = '{32'h00000005, 2'b01, 8'd0,    1'b0, 1'b0, 32'h00000005, 1'b0};

    RST = 1'b0; IN_VALID = 1'b0; INA = '0; SHTYPE = '0; AMOUNT = '0; IMM = 1'b0;
    CIN = 1'b0; TAG = '0; OUT_READY = 1'b1;
    #1 RST = 1'b1;

    // reset state
    repeat (2) @(negedge CLK);
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_out", 64'(OUT), 64'd0);
    chk("rst_cout", 64'(COUT), 64'd0);
    chk("rst_tag_out", 64'(TAG_OUT), 64'd0);
    chk("rst_in_ready", 64'(IN_READY), 64'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("in_ready_after_rst", 64'(IN_READY), 64'd1);
    @(posedge CLK);
    #1;

    // directed vectors with latency check
    for (int i = 0; i < 16; i++) begin
      send(tbl[i].a, tbl[i].t, tbl[i].amt, tbl[i].imm, tbl[i].c, TW'(i), {tbl[i].eo, tbl[i].ec});
      lat = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge CLK);
        lat++;
        if (OUT_VALID) break;
      end
      chk($sformatf("latency_vec%0d", i), 64'(lat), 64'(LAT));
      @(posedge CLK);
      #1;
    end
    drain("drain_table");

    // stream tags 1..6 with a 4-cycle output stall
    dropped = 0;
    seen0 = out_seen;
    fork
      begin
        for (int tg = 1; tg <= 6; tg++) begin
          ra = $urandom; rt = 2'(tg); ramt = 8'($urandom_range(0, 40)); ri = tg[0]; rc = 1'($urandom);
          send(ra, rt, ramt, ri, rc, TW'(tg), model(ra, rt, ramt, ri, rc));
        end
      end
      begin
        repeat (2) @(posedge CLK);
        #1 OUT_READY = 1'b0;
        repeat (4) begin
          @(negedge CLK);
          if (!IN_READY) dropped = 1;
          @(posedge CLK);
          #1;
        end
        OUT_READY = 1'b1;
      end
    join
    chk("stall_in_ready_drop", 64'(dropped), 64'd1);
    drain("drain_stream");
    chk("stream_count", 64'(out_seen - seen0), 64'd6);

    // reset one cycle after accepting tag 7
    OUT_READY = 1'b0;
    ra = 32'hDEADBEEF;
    send(ra, 2'b01, 8'd3, 1'b0, 1'b0, 4'd7, model(ra, 2'b01, 8'd3, 1'b0, 1'b0));
    @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("midrst_out", 64'(OUT), 64'd0);
    chk("midrst_tag_out", 64'(TAG_OUT), 64'd0);
    chk("midrst_in_ready", 64'(IN_READY), 64'd0);
    exp_q.delete();
    seen0 = out_seen;
    @(posedge CLK);
    #1 RST = 1'b0;
    OUT_READY = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    chk("tag7_never_emerges", 64'(out_seen - seen0), 64'd0);

    // random traffic with random backpressure
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          ra = $urandom; rt = 2'($urandom_range(0, 3)); ri = 1'($urandom); rc = 1'($urandom);
          case ($urandom_range(0, 5))
            0: ramt = 8'd0;
            1: ramt = 8'd32;
            2: ramt = 8'd33;
            3: ramt = 8'($urandom_range(1, 31));
            4: ramt = 8'($urandom_range(0, 255));
            default: ramt = 8'd64;
          endcase
          send(ra, rt, ramt, ri, rc, TW'(i), model(ra, rt, ramt, ri, rc));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge CLK);
            #1;
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge CLK);
          #1 OUT_READY = ($urandom_range(0, 3) != 0);
        end
        OUT_READY = 1'b1;
      end
    join
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
